rr_arbiter8: RTL



---
 rtl/rr_arbiter8.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, owner index,
// idle/none flag and an optional hold timeout that forces release of a stuck owner.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       eo,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic          HOLD_EN   = (MAX_HOLD != 0);

    state_t        state_reg, state_next;
    logic [7:0]    gnt_reg, gnt_next;
    logic [2:0]    id_reg, id_next;
    logic          valid_reg, valid_next;
    logic          eo_reg, eo_next;
    logic          to_reg, to_next;
    logic [2:0]    ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [7:0]    rot_req;
    logic [2:0]    sel_off;
    logic [2:0]    sel;
    logic          rel_done, rel_wd, rel_to, release_now;

    // Requests rotated so that bit 0 is the requester currently holding top priority.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[3'(ptr_reg + 3'(gi))];
        end
    endgenerate

    always_comb begin
        sel_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) sel_off = 3'(i);
        end
    end

    assign sel         = ptr_reg + sel_off;
    assign rel_done    = done;
    assign rel_wd      = ~req[id_reg];
    assign rel_to      = HOLD_EN && (cnt_reg == HOLD_LAST);
    assign release_now = rel_done | rel_wd | rel_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req)       state_next = GRANT;
            GRANT:   if (release_now) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_next   = gnt_reg;
        id_next    = id_reg;
        valid_next = valid_reg;
        eo_next    = eo_reg;
        to_next    = 1'b0;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_next   = 8'(8'b1 << sel);
                    id_next    = sel;
                    valid_next = 1'b1;
                    eo_next    = 1'b0;
                    cnt_next   = '0;
                end else begin
                    gnt_next   = 8'h00;
                    valid_next = 1'b0;
                    eo_next    = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_next   = 8'h00;
                    valid_next = 1'b0;
                    ptr_next   = id_reg + 3'd1;
                    cnt_next   = '0;
                    eo_next    = ~|req;
                    // Flag only a pure timeout, not one coinciding with a normal release.
                    to_next    = rel_to & ~rel_done & ~rel_wd;
                end else begin
                    eo_next    = 1'b0;
                    cnt_next   = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
                end
            end
            default: begin
                gnt_next   = 8'h00;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_reg   <= 8'h00;
            id_reg    <= 3'd0;
            valid_reg <= 1'b0;
            eo_reg    <= 1'b1;
            to_reg    <= 1'b0;
            ptr_reg   <= 3'd0;
            cnt_reg   <= '0;
        end else begin
            gnt_reg   <= gnt_next;
            id_reg    <= id_next;
            valid_reg <= valid_next;
            eo_reg    <= eo_next;
            to_reg    <= to_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = id_reg;
    assign gnt_valid = valid_reg;
    assign eo        = eo_reg;
    assign timeout   = to_reg;

endmodule
